accum_alu_seq: RTL and testbench

ACCUM_ALU_SEQ -- requirements
Module: accum_alu_seq

---
 rtl/alu_pkg.sv | 22 ++
 rtl/seq_mult.sv | 61 ++++++
 rtl/accum_alu_seq.sv | 138 +++++++++++++
 tb/tb_accum_alu_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op-code and FSM-state encodings for the accumulator ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOT  = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_MUL  = 3'b110,
        OP_LOAD = 3'b111
    } aluOp_t;

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_READY = 2'b01,
        ST_RUN   = 2'b10,
        ST_ERROR = 2'b11
    } aluState_t;

endpackage

// File: rtl/seq_mult.sv
// Iterative unsigned shift-add multiplier: start loads operands, the full
// product is presented with done exactly WIDTH edges after the start edge.
module seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] mcandQ;
    logic [2*WIDTH-1:0] partialQ;
    logic [WIDTH-1:0]   mplierQ;
    logic [CW-1:0]      countQ;
    logic               busyQ;
    logic [2*WIDTH-1:0] addend;
    logic               lastStep;

    assign addend   = mplierQ[0] ? mcandQ : '0;
    assign lastStep = busyQ && (countQ == CW'(WIDTH - 1));

    // The final bit is folded in combinationally so the owner can capture
    // the product on the WIDTH-th edge instead of one edge later.
    assign done    = lastStep;
    assign product = partialQ + addend;

    // NOTE: the datapath registers are cleared on reset/abort as well as the
    // control bits, so a restarted multiply never sees stale partial sums.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            mcandQ   <= '0;
            partialQ <= '0;
            mplierQ  <= '0;
            countQ   <= '0;
            busyQ    <= 1'b0;
        end else if (start) begin
            mcandQ   <= {{WIDTH{1'b0}}, a};
            partialQ <= '0;
            mplierQ  <= b;
            countQ   <= '0;
            busyQ    <= 1'b1;
        end else if (busyQ) begin
            if (lastStep) begin
                busyQ <= 1'b0;
            end else begin
                partialQ <= partialQ + addend;
                mcandQ   <= mcandQ << 1;
                mplierQ  <= mplierQ >> 1;
                countQ   <= countQ + 1'b1;
            end
        end
    end

endmodule

// File: rtl/accum_alu_seq.sv
// Accumulator ALU with a power/ready/run/error FSM; single-cycle logic and
// add/sub ops, WIDTH-cycle iterative multiply via seq_mult.
module accum_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic             clr_err,
    output logic [WIDTH-1:0] acc,
    output logic             out_valid,
    output logic             overflow,
    output logic             error,
    output logic [1:0]       state
);

    aluState_t          stateQ, stateD;
    logic [WIDTH-1:0]   accQ, accD;
    logic               outValidQ, outValidD;
    logic               overflowQ, overflowD;

    logic [WIDTH:0]     sumWide;
    logic [WIDTH-1:0]   aluResult;
    logic               aluOvf;

    logic               mulStart;
    logic               mulDone;
    logic [2*WIDTH-1:0] mulProduct;
    logic               mulOvf;

    seq_mult #(.WIDTH(WIDTH)) uMult (
        .clk     (clk),
        .rst     (rst),
        .start   (mulStart),
        .abort   (!on),
        .a       (accQ),
        .b       (operand),
        .done    (mulDone),
        .product (mulProduct)
    );

    assign mulOvf = |mulProduct[2*WIDTH-1:WIDTH];

    // NOTE: every combinational output gets a default before the case so no
    // path leaves a value unassigned and infers a latch.
    always_comb begin
        sumWide   = '0;
        aluResult = accQ;
        aluOvf    = 1'b0;
        case (op)
            OP_AND:  aluResult = accQ & operand;
            OP_OR:   aluResult = accQ | operand;
            OP_XOR:  aluResult = accQ ^ operand;
            OP_NOT:  aluResult = ~accQ;
            OP_ADD: begin
                sumWide   = {1'b0, accQ} + {1'b0, operand};
                aluResult = sumWide[WIDTH-1:0];
                aluOvf    = sumWide[WIDTH];
            end
            OP_SUB: begin
                aluResult = accQ - operand;
                aluOvf    = operand > accQ;
            end
            OP_LOAD: aluResult = operand;
            default: aluResult = accQ;
        endcase
    end

    always_comb begin
        stateD    = stateQ;
        accD      = accQ;
        outValidD = 1'b0;
        overflowD = 1'b0;
        mulStart  = 1'b0;
        if (!on) begin
            stateD = ST_OFF;
        end else begin
            case (stateQ)
                ST_OFF:   stateD = ST_READY;
                ST_READY: begin
                    if (in_valid) begin
                        if (op == OP_MUL) begin
                            mulStart = 1'b1;
                            stateD   = ST_RUN;
                        end else begin
                            accD      = aluResult;
                            outValidD = 1'b1;
                            overflowD = aluOvf;
                            stateD    = aluOvf ? ST_ERROR : ST_READY;
                        end
                    end
                end
                ST_RUN: begin
                    if (mulDone) begin
                        accD      = mulProduct[WIDTH-1:0];
                        outValidD = 1'b1;
                        overflowD = mulOvf;
                        stateD    = mulOvf ? ST_ERROR : ST_READY;
                    end
                end
                ST_ERROR: begin
                    if (clr_err) stateD = ST_READY;
                end
                default:  stateD = ST_OFF;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= ST_OFF;
            accQ      <= '0;
            outValidQ <= 1'b0;
            overflowQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            accQ      <= accD;
            outValidQ <= outValidD;
            overflowQ <= overflowD;
        end
    end

    assign in_ready  = (stateQ == ST_READY) && on;
    assign error     = (stateQ == ST_ERROR);
    assign acc       = accQ;
    assign out_valid = outValidQ;
    assign overflow  = overflowQ;
    assign state     = stateQ;

endmodule

// File: tb/tb_accum_alu_seq.sv
// Directed self-checking bench for accum_alu_seq at WIDTH=8.
module tb_accum_alu_seq;
    import alu_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             on;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] operand;
    logic             clr_err;
    logic [WIDTH-1:0] acc;
    logic             out_valid;
    logic             overflow;
    logic             error;
    logic [1:0]       state;

    int checks   = 0;
    int failures = 0;

    accum_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .on        (on),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand   (operand),
        .clr_err   (clr_err),
        .acc       (acc),
        .out_valid (out_valid),
        .overflow  (overflow),
        .error     (error),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] opc, input logic [WIDTH-1:0] val);
        in_valid = 1'b1;
        op       = opc;
        operand  = val;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic result(input string tag, input logic [WIDTH-1:0] expAcc, input logic expOvf, input logic [1:0] expState);
        check({tag, ".acc"}, acc, expAcc);
        check({tag, ".out_valid"}, out_valid, 1'b1);
        check({tag, ".overflow"}, overflow, expOvf);
        check({tag, ".state"}, state, expState);
    endtask

    task automatic clearError();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_err.state", state, ST_READY);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; on = 1'b0; in_valid = 1'b0; op = '0; operand = '0; clr_err = 1'b0;
        #1;
        tick();
        tick();
        rst = 1'b0;
        check("reset.state", state, ST_OFF);
        check("reset.acc", acc, 8'h00);
        check("reset.out_valid", out_valid, 1'b0);
        check("reset.overflow", overflow, 1'b0);
        check("reset.in_ready", in_ready, 1'b0);

        // Commands while OFF, including the edge where on rises, are dropped.
        in_valid = 1'b1; op = OP_LOAD; operand = 8'h33;
        tick();
        check("off_ignore.acc", acc, 8'h00);
        check("off_ignore.out_valid", out_valid, 1'b0);
        on = 1'b1;
        tick();
        in_valid = 1'b0;
        check("power_up.state", state, ST_READY);
        check("power_up.acc", acc, 8'h00);
        check("power_up.out_valid", out_valid, 1'b0);
        check("power_up.in_ready", in_ready, 1'b1);

        // LOAD 0x0F then ADD 0xF1: carry out, wraps to zero, ERROR.
        cmd(OP_LOAD, 8'h0F);
        result("load0f", 8'h0F, 1'b0, ST_READY);
        cmd(OP_ADD, 8'hF1);
        result("add_carry", 8'h00, 1'b1, ST_ERROR);
        check("add_carry.error", error, 1'b1);
        check("add_carry.in_ready", in_ready, 1'b0);
        in_valid = 1'b1; op = OP_LOAD; operand = 8'h77;
        tick();
        in_valid = 1'b0;
        check("err_ignore.out_valid", out_valid, 1'b0);
        check("err_ignore.overflow", overflow, 1'b0);
        check("err_ignore.acc", acc, 8'h00);
        check("err_ignore.state", state, ST_ERROR);
        clearError();
        check("clr_err.error", error, 1'b0);

        // MUL 0x0C*0x0B = 0x84; requests during RUN are ignored.
        cmd(OP_LOAD, 8'h0C);
        cmd(OP_MUL, 8'h0B);
        check("mul.run_state", state, ST_RUN);
        check("mul.in_ready0", in_ready, 1'b0);
        check("mul.no_pulse0", out_valid, 1'b0);
        in_valid = 1'b1; op = OP_LOAD; operand = 8'hEE;
        for (int i = 1; i < WIDTH; i++) begin
            tick();
            check($sformatf("mul.in_ready%0d", i), in_ready, 1'b0);
            check($sformatf("mul.acc_hold%0d", i), acc, 8'h0C);
            check($sformatf("mul.no_pulse%0d", i), out_valid, 1'b0);
        end
        tick();
        in_valid = 1'b0;
        result("mul_0c_0b", 8'h84, 1'b0, ST_READY);
        tick();
        check("mul.pulse_once", out_valid, 1'b0);
        check("mul.ovf_clear", overflow, 1'b0);

        // MUL 0x10*0x10 = 0x100: truncated to 0, overflow, ERROR.
        cmd(OP_LOAD, 8'h10);
        cmd(OP_MUL, 8'h10);
        repeat (WIDTH - 1) tick();
        check("mul_ovf.acc_hold", acc, 8'h10);
        tick();
        result("mul_10_10", 8'h00, 1'b1, ST_ERROR);
        clearError();

        // Borrow and non-borrow subtraction.
        cmd(OP_LOAD, 8'h05);
        cmd(OP_SUB, 8'h07);
        result("sub_borrow", 8'hFE, 1'b1, ST_ERROR);
        clearError();
        cmd(OP_LOAD, 8'h07);
        cmd(OP_SUB, 8'h05);
        result("sub_ok", 8'h02, 1'b0, ST_READY);

        // Logic ops, NOT, and an equal-operand subtract.
        cmd(OP_LOAD, 8'hAA);
        cmd(OP_NOT, 8'h00);
        result("not_aa", 8'h55, 1'b0, ST_READY);
        cmd(OP_AND, 8'h0F);
        result("and", 8'h05, 1'b0, ST_READY);
        cmd(OP_OR, 8'hA0);
        result("or", 8'hA5, 1'b0, ST_READY);
        cmd(OP_XOR, 8'hFF);
        result("xor", 8'h5A, 1'b0, ST_READY);
        cmd(OP_ADD, 8'h10);
        result("add_ok", 8'h6A, 1'b0, ST_READY);
        cmd(OP_SUB, 8'h6A);
        result("sub_equal", 8'h00, 1'b0, ST_READY);

        // Power-off during RUN aborts the multiply.
        cmd(OP_LOAD, 8'h03);
        cmd(OP_MUL, 8'h05);
        tick();
        tick();
        on = 1'b0;
        tick();
        check("abort_off.state", state, ST_OFF);
        check("abort_off.acc", acc, 8'h03);
        check("abort_off.out_valid", out_valid, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            tick();
            check($sformatf("abort_off.quiet%0d", i), out_valid, 1'b0);
        end
        check("abort_off.acc_final", acc, 8'h03);
        on = 1'b1;
        tick();
        check("repower.state", state, ST_READY);

        // Reset during RUN abandons the multiply and clears acc.
        cmd(OP_MUL, 8'h05);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_rst.state", state, ST_OFF);
        check("abort_rst.acc", acc, 8'h00);
        check("abort_rst.out_valid", out_valid, 1'b0);
        tick();
        check("abort_rst.ready", state, ST_READY);
        for (int i = 0; i < WIDTH; i++) begin
            check($sformatf("abort_rst.quiet%0d", i), out_valid, 1'b0);
            tick();
        end

        // Multiplier restarts cleanly after both aborts: 0x09*0x03 = 0x1B.
        cmd(OP_LOAD, 8'h09);
        cmd(OP_MUL, 8'h03);
        repeat (WIDTH) tick();
        result("mul_09_03", 8'h1B, 1'b0, ST_READY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
